// File: rtl/bp_be_loop_inference_sched_if.sv
// Requester and loop-inference-unit signals of the loop inference scheduler.
// The master side (requesters plus the unit) drives the *_i signals, and the
// slave side (the scheduler) drives the *_o signals.
interface bp_be_loop_inference_sched_if #(
  parameter int unsigned num_req_p      = 4,
  parameter int unsigned vaddr_width_p  = 39,
  parameter int unsigned output_range_p = 8
);
  logic [num_req_p-1:0]               req_v_i;
  logic [num_req_p*vaddr_width_p-1:0] req_pc_i;
  logic [num_req_p-1:0]               req_ready_o;
  logic [num_req_p-1:0]               confirm_i;
  logic [num_req_p-1:0]               resp_v_o;
  logic [output_range_p-1:0]          resp_count_o;
  logic                               resp_aborted_o;
  logic [num_req_p-1:0]               resp_yumi_i;
  logic                               start_discovery_o;
  logic [vaddr_width_p-1:0]           striding_pc_o;
  logic                               confirm_discovery_o;
  logic [output_range_p-1:0]          li_count_i;
  logic                               li_v_i;
  logic                               li_yumi_o;

  modport master (
    output req_v_i, req_pc_i, confirm_i, resp_yumi_i, li_count_i, li_v_i,
    input  req_ready_o, resp_v_o, resp_count_o, resp_aborted_o,
           start_discovery_o, striding_pc_o, confirm_discovery_o, li_yumi_o
  );

  modport slave (
    input  req_v_i, req_pc_i, confirm_i, resp_yumi_i, li_count_i, li_v_i,
    output req_ready_o, resp_v_o, resp_count_o, resp_aborted_o,
           start_discovery_o, striding_pc_o, confirm_discovery_o, li_yumi_o
  );
endinterface

// File: rtl/bp_be_loop_inference_sched.sv
// Shares one loop-inference unit among several striding-load detectors.
// It grants discovery sessions round-robin, forwards only the owner's confirm,
// times out unconfirmed sessions, and hands the result back to the owner.
module bp_be_loop_inference_sched #(
  parameter int unsigned num_req_p      = 4,
  parameter int unsigned vaddr_width_p  = 39,
  parameter int unsigned output_range_p = 8,
  parameter int unsigned timeout_p      = 1024
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bp_be_loop_inference_sched_if.slave   bus,
  output logic                          busy_o,
  output logic [$clog2(num_req_p)-1:0]  owner_o
);

  localparam int unsigned idx_w_lp = $clog2(num_req_p);
  localparam int unsigned cnt_w_lp = $clog2(timeout_p);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    SEARCH  = 2'd2,
    DELIVER = 2'd3
  } state_e;

  state_e                    state_r, state_n;
  logic [idx_w_lp-1:0]       rr_r, owner_r, grant_idx;
  logic                      grant_v;
  logic [vaddr_width_p-1:0]  pc_r, grant_pc;
  logic [cnt_w_lp-1:0]       counter_r;
  logic                      confirmed_r;
  logic [output_range_p-1:0] count_r;
  logic                      aborted_r;
  logic                      own_confirm, abort_now;
  logic [num_req_p-1:0]      req_ready_c;
  logic                      li_yumi_c, confirm_disc_c;

  assign own_confirm = bus.confirm_i[owner_r];
  // An unconfirmed session on its last allowed SEARCH cycle with no result and no confirm
  assign abort_now = (counter_r == cnt_w_lp'(timeout_p - 1)) && !confirmed_r
                     && !own_confirm && !bus.li_v_i;

  // Round-robin pick: the first active request at or after the rr pointer, with its PC
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    grant_pc  = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      if (!grant_v && bus.req_v_i[rr_r + idx_w_lp'(k)]) begin
        grant_v   = 1'b1;
        grant_idx = rr_r + idx_w_lp'(k);
      end
    end
    for (int unsigned k = 0; k < num_req_p; k++) begin
      if (grant_idx == idx_w_lp'(k)) begin
        grant_pc = bus.req_pc_i[k*vaddr_width_p +: vaddr_width_p];
      end
    end
  end

  // Session state register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state and combinational handshake outputs
  always_comb begin
    state_n        = state_r;
    req_ready_c    = '0;
    li_yumi_c      = 1'b0;
    confirm_disc_c = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (grant_v) begin
          req_ready_c = num_req_p'(1) << grant_idx;
          state_n     = START;
        end
      end
      START: begin
        state_n = SEARCH;
      end
      SEARCH: begin
        confirm_disc_c = own_confirm | confirmed_r;
        if (bus.li_v_i) begin
          li_yumi_c = 1'b1;
          state_n   = DELIVER;
        end else if (abort_now) begin
          state_n = DELIVER;
        end
      end
      DELIVER: begin
        if (bus.resp_yumi_i[owner_r]) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Session datapath: owner/PC capture, timeout counter, confirm latch, result
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_r        <= '0;
      owner_r     <= '0;
      pc_r        <= '0;
      counter_r   <= '0;
      confirmed_r <= 1'b0;
      count_r     <= '0;
      aborted_r   <= 1'b0;
    end else begin
      unique case (state_r)
        IDLE: begin
          if (grant_v) begin
            pc_r    <= grant_pc;
            owner_r <= grant_idx;
            rr_r    <= grant_idx + idx_w_lp'(1);
          end
        end
        START: begin
          counter_r   <= '0;
          confirmed_r <= 1'b0;
        end
        SEARCH: begin
          if (!confirmed_r) begin
            counter_r <= counter_r + cnt_w_lp'(1);
          end
          if (own_confirm) begin
            confirmed_r <= 1'b1;
          end
          if (bus.li_v_i) begin
            count_r   <= bus.li_count_i;
            aborted_r <= 1'b0;
          end else if (abort_now) begin
            count_r   <= '0;
            aborted_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o         = req_ready_c;
  assign bus.li_yumi_o           = li_yumi_c;
  assign bus.confirm_discovery_o = confirm_disc_c;
  assign bus.start_discovery_o   = (state_r == START);
  assign bus.striding_pc_o       = pc_r;
  assign bus.resp_v_o            = (state_r == DELIVER) ? (num_req_p'(1) << owner_r) : '0;
  assign bus.resp_count_o        = count_r;
  assign bus.resp_aborted_o      = aborted_r;
  assign busy_o                  = (state_r != IDLE);
  assign owner_o                 = owner_r;

endmodule

// File: tb/tb_bp_be_loop_inference_sched.sv
// Bench for the loop inference scheduler. It drives directed sessions and checks
// the DUT every cycle against a session-level model, plus literal expectations.
module tb_bp_be_loop_inference_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned VW = 39;
  localparam int unsigned OW = 8;
  localparam int unsigned TO = 16;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       busy_o;
  logic [1:0] owner_o;

  always #5 clk_i = ~clk_i;

  bp_be_loop_inference_sched_if #(.num_req_p(N), .vaddr_width_p(VW), .output_range_p(OW)) bus();

  bp_be_loop_inference_sched #(
    .num_req_p(N), .vaddr_width_p(VW), .output_range_p(OW), .timeout_p(TO)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .bus      (bus),
    .busy_o   (busy_o),
    .owner_o  (owner_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [VW-1:0] tb_pc [N];

  // Session-level model: phase 0 idle, 1 start, 2 search, 3 deliver.
  // Timeout is measured as elapsed SEARCH cycles since the session began.
  int            m_phase = 0;
  int            m_owner = 0;
  int            m_rr    = 0;
  logic [VW-1:0] m_pc    = '0;
  logic [OW-1:0] m_cnt   = '0;
  bit            m_ab    = 1'b0;
  bit            m_conf  = 1'b0;
  int            m_t0    = 0;
  int            cyc     = 0;
  bit            m_valid = 1'b0;
  int            mp;
  bit            mc;

  function automatic int pick();
    for (int k = 0; k < int'(N); k++) begin
      if (bus.req_v_i[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  // Model update on each active edge, from the same inputs the DUT samples
  always @(posedge clk_i) begin
    cyc++;
    if (!reset_n_i) begin
      m_phase = 0; m_owner = 0; m_rr = 0; m_pc = '0;
      m_cnt = '0; m_ab = 1'b0; m_conf = 1'b0; m_valid = 1'b1;
    end else begin
      case (m_phase)
        0: begin
          mp = pick();
          if (mp >= 0) begin
            m_owner = mp;
            m_rr    = (mp + 1) % N;
            m_pc    = tb_pc[mp];
            m_phase = 1;
          end
        end
        1: begin
          m_conf  = 1'b0;
          m_t0    = cyc;
          m_phase = 2;
        end
        2: begin
          mc = bus.confirm_i[m_owner];
          if (bus.li_v_i) begin
            m_cnt = bus.li_count_i; m_ab = 1'b0; m_phase = 3;
          end else if (!m_conf && !mc && (cyc - m_t0 == int'(TO))) begin
            m_cnt = '0; m_ab = 1'b1; m_phase = 3;
          end
          if (mc) m_conf = 1'b1;
        end
        default: begin
          if (bus.resp_yumi_i[m_owner]) m_phase = 0;
        end
      endcase
    end
  end

  logic [N-1:0] e_rdy, e_rv;
  int           ep;

  // Per-cycle compare of every DUT output against the model
  always @(negedge clk_i) begin
    if (m_valid) begin
      ep    = pick();
      e_rdy = (m_phase == 0 && ep >= 0) ? N'(1) << ep : '0;
      e_rv  = (m_phase == 3) ? N'(1) << m_owner : '0;
      chk("req_ready", 64'(bus.req_ready_o), 64'(e_rdy));
      chk("resp_v", 64'(bus.resp_v_o), 64'(e_rv));
      chk("resp_count", 64'(bus.resp_count_o), 64'(m_cnt));
      chk("resp_aborted", 64'(bus.resp_aborted_o), 64'(m_ab));
      chk("start_discovery", 64'(bus.start_discovery_o), 64'(m_phase == 1));
      chk("striding_pc", 64'(bus.striding_pc_o), 64'(m_pc));
      chk("confirm_discovery", 64'(bus.confirm_discovery_o),
          64'(m_phase == 2 && (bus.confirm_i[m_owner] || m_conf)));
      chk("li_yumi", 64'(bus.li_yumi_o), 64'(m_phase == 2 && bus.li_v_i));
      chk("busy", 64'(busy_o), 64'(m_phase != 0));
      chk("owner", 64'(owner_o), 64'(m_owner));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Session boilerplate: idle -> accept edge -> start -> first SEARCH cycle
  task automatic open_session(input logic [N-1:0] req);
    bus.req_v_i = req;
    tick();
    bus.req_v_i = '0;
    tick();
  endtask

  task automatic consume(input logic [N-1:0] y);
    bus.resp_yumi_i = y;
    tick();
    bus.resp_yumi_i = '0;
  endtask

  int budget;

  initial begin
    bus.req_v_i = '0; bus.req_pc_i = '0; bus.confirm_i = '0;
    bus.resp_yumi_i = '0; bus.li_count_i = '0; bus.li_v_i = 1'b0;
    tb_pc[0] = 39'h00_8000_0040;
    tb_pc[1] = 39'h00_8000_1100;
    tb_pc[2] = 39'h00_8000_2200;
    tb_pc[3] = 39'h00_8000_3300;
    for (int k = 0; k < int'(N); k++) bus.req_pc_i[k*VW +: VW] = tb_pc[k];

    // Reset state
    reset_n_i = 1'b0;
    tick(); tick();
    settle();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_pc", 64'(bus.striding_pc_o), 64'd0);
    chk("rst_resp_v", 64'(bus.resp_v_o), 64'd0);
    chk("rst_owner", 64'(owner_o), 64'd0);
    reset_n_i = 1'b1;
    tick();

    // Single flow, requester 0
    bus.req_v_i = 4'b0001;
    settle();
    chk("flow_ready", 64'(bus.req_ready_o), 64'h1);
    tick();
    bus.req_v_i = '0;
    settle();
    chk("flow_start", 64'(bus.start_discovery_o), 64'd1);
    chk("flow_pc", 64'(bus.striding_pc_o), 64'h8000_0040);
    tick();
    for (int s = 1; s <= 9; s++) begin
      if (s == 5) bus.confirm_i = 4'b0001;
      if (s == 9) begin bus.li_v_i = 1'b1; bus.li_count_i = 8'd12; end
      settle();
      if (s == 4) chk("flow_conf_before", 64'(bus.confirm_discovery_o), 64'd0);
      if (s == 5) chk("flow_conf_pulse", 64'(bus.confirm_discovery_o), 64'd1);
      if (s == 7) chk("flow_conf_held", 64'(bus.confirm_discovery_o), 64'd1);
      if (s == 9) chk("flow_li_yumi", 64'(bus.li_yumi_o), 64'd1);
      tick();
      bus.confirm_i = '0;
      bus.li_v_i = 1'b0;
    end
    bus.li_v_i = 1'b1;
    settle();
    chk("flow_resp_v", 64'(bus.resp_v_o), 64'h1);
    chk("flow_count", 64'(bus.resp_count_o), 64'd12);
    chk("flow_aborted", 64'(bus.resp_aborted_o), 64'd0);
    chk("flow_li_ignored", 64'(bus.li_yumi_o), 64'd0);
    bus.li_v_i = 1'b0;
    consume(4'b0001);
    settle();
    chk("flow_idle", 64'(busy_o), 64'd0);

    // Contention from a fresh rr pointer: grants 0,1,2,3,0
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    bus.req_v_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      settle();
      budget = 0;
      while (bus.req_ready_o == '0 && budget < 8) begin tick(); budget++; end
      chk("cont_grant_seen", 64'(bus.req_ready_o != '0), 64'd1);
      chk("cont_grant", 64'(bus.req_ready_o), 64'(N'(1) << (k % 4)));
      tick();
      settle();
      chk("cont_owner", 64'(owner_o), 64'(k % 4));
      chk("cont_pc", 64'(bus.striding_pc_o), 64'(tb_pc[k % 4]));
      tick();
      bus.li_v_i = 1'b1; bus.li_count_i = 8'(k + 1);
      tick();
      bus.li_v_i = 1'b0;
      settle();
      chk("cont_count", 64'(bus.resp_count_o), 64'(k + 1));
      consume(N'(1) << (k % 4));
    end
    bus.req_v_i = '0;
    tick();

    // Timeout: requester 3, no confirm, no result
    bus.req_v_i = 4'b1000;
    settle();
    chk("to_ready", 64'(bus.req_ready_o), 64'h8);
    open_session(4'b1000);
    for (int s = 1; s <= int'(TO); s++) begin
      settle();
      chk("to_not_yet", 64'(bus.resp_v_o), 64'd0);
      chk("to_no_confirm", 64'(bus.confirm_discovery_o), 64'd0);
      tick();
    end
    settle();
    chk("to_resp_v", 64'(bus.resp_v_o), 64'h8);
    chk("to_aborted", 64'(bus.resp_aborted_o), 64'd1);
    chk("to_count", 64'(bus.resp_count_o), 64'd0);
    consume(4'b1000);

    // Boundary: owner confirm on the timeout cycle, result 40 cycles later
    open_session(4'b0010);
    for (int s = 1; s <= int'(TO); s++) begin
      if (s == int'(TO)) bus.confirm_i = 4'b0010;
      settle();
      if (s == int'(TO)) chk("bnd_conf", 64'(bus.confirm_discovery_o), 64'd1);
      tick();
      bus.confirm_i = '0;
    end
    for (int w = 1; w <= 40; w++) begin
      if (w == 40) begin bus.li_v_i = 1'b1; bus.li_count_i = 8'd7; end
      settle();
      if (w == 20) chk("bnd_still_search", 64'(bus.resp_v_o), 64'd0);
      tick();
      bus.li_v_i = 1'b0;
    end
    settle();
    chk("bnd_resp_v", 64'(bus.resp_v_o), 64'h2);
    chk("bnd_aborted", 64'(bus.resp_aborted_o), 64'd0);
    chk("bnd_count", 64'(bus.resp_count_o), 64'd7);
    consume(4'b0010);

    // Boundary: result on the timeout cycle wins
    open_session(4'b0100);
    for (int s = 1; s <= int'(TO); s++) begin
      if (s == int'(TO)) begin bus.li_v_i = 1'b1; bus.li_count_i = 8'h55; end
      settle();
      tick();
      bus.li_v_i = 1'b0;
    end
    settle();
    chk("race_resp_v", 64'(bus.resp_v_o), 64'h4);
    chk("race_aborted", 64'(bus.resp_aborted_o), 64'd0);
    chk("race_count", 64'(bus.resp_count_o), 64'h55);
    consume(4'b0100);

    // Isolation: owner 2 ignores requester 0 confirm and yumi
    open_session(4'b0100);
    settle();
    chk("iso_owner", 64'(owner_o), 64'd2);
    bus.confirm_i = 4'b0001;
    settle();
    chk("iso_conf_pulse", 64'(bus.confirm_discovery_o), 64'd0);
    tick();
    bus.confirm_i = '0;
    settle();
    chk("iso_conf_after", 64'(bus.confirm_discovery_o), 64'd0);
    bus.li_v_i = 1'b1; bus.li_count_i = 8'd9;
    tick();
    bus.li_v_i = 1'b0;
    consume(4'b0001);
    settle();
    chk("iso_hold", 64'(bus.resp_v_o), 64'h4);
    consume(4'b0100);
    settle();
    chk("iso_release", 64'(busy_o), 64'd0);

    // Reset mid-SEARCH, then a fresh grant to requester 1
    open_session(4'b0001);
    tick(); tick();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    settle();
    chk("mid_busy", 64'(busy_o), 64'd0);
    chk("mid_pc", 64'(bus.striding_pc_o), 64'd0);
    chk("mid_count", 64'(bus.resp_count_o), 64'd0);
    chk("mid_owner", 64'(owner_o), 64'd0);
    bus.req_v_i = 4'b0010;
    settle();
    chk("mid_ready", 64'(bus.req_ready_o), 64'h2);
    tick();
    bus.req_v_i = '0;
    settle();
    chk("mid_owner1", 64'(owner_o), 64'd1);
    tick();
    bus.li_v_i = 1'b1; bus.li_count_i = 8'd3;
    tick();
    bus.li_v_i = 1'b0;
    consume(4'b0010);
    settle();
    chk("mid_done", 64'(busy_o), 64'd0);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/bp_be_loop_inference_sched.md
Name: bp_be_loop_inference_sched

Overview:
- Scheduler that shares one loop-inference unit among several striding-load detectors in the BE checker.
- Round-robin grants discovery sessions and pulses start_discovery to the unit with the winner's striding PC.
- Forwards only the owner's confirm and times out unconfirmed sessions.
- Returns the iteration estimate, or an abort, to the owning requester through a valid/yumi handshake.

Parameters:
- num_req_p, 4, number of requesters (power of 2, ≥2)
- vaddr_width_p, from bp_params_p, striding PC width
- output_range_p, 8, iteration-count width
- timeout_p, 1024, SEARCH cycles allowed before an unconfirmed session aborts (≥2)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; synchronous, active-low
- req_v_i  in  num_req_p  per-requester discovery request; held until accepted
- req_pc_i  in  num_req_p*vaddr_width_p  striding PC per requester; slice i belongs to requester i
- req_ready_o  out  num_req_p  one-hot accept
- confirm_i  in  num_req_p  per-requester confirm pulse
- resp_v_o  out  num_req_p  one-hot result valid, owner only
- resp_count_o  out  output_range_p  remaining-iteration estimate
- resp_aborted_o  out  1  session timed out; count is 0
- resp_yumi_i  in  num_req_p  result consume
- start_discovery_o  out  1  start pulse to the unit
- striding_pc_o  out  vaddr_width_p  PC to the unit
- confirm_discovery_o  out  1  confirm to the unit
- li_count_i  in  output_range_p  unit estimate
- li_v_i  in  1  unit estimate valid
- li_yumi_o  out  1  unit estimate consume
- busy_o  out  1  state != IDLE
- owner_o  out  $clog2(num_req_p)  current owner index

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - state=IDLE, rr pointer=0, owner=0, counter=0, confirmed_r=0.
  - All outputs 0, including striding_pc_o and resp_count_o.
  - Reset mid-session drops the session silently; the unit must be reset in the same cycle.
- IDLE:
  - Round-robin arbiter picks the first req_v_i at or after the rr pointer.
  - req_ready_o asserts combinationally for that requester.
  - On the accept edge: latch PC and owner, advance rr pointer to owner+1 (mod num_req_p), go to START.
  - No request → stay in IDLE.
- START:
  - start_discovery_o=1 for exactly one cycle; striding_pc_o carries the latched PC from START onward.
  - Clear counter and confirmed_r, then go to SEARCH.
  - Request accept is at cycle T, start pulse at T+1.
- SEARCH:
  - confirm_discovery_o = confirm_i[owner] | confirmed_r. confirmed_r sets on confirm_i[owner].
  - Non-owner confirm_i bits are ignored.
  - Counter increments each cycle while confirmed_r=0.
  - li_v_i=1: li_yumi_o=1 in the same cycle, latch li_count_i, aborted=0, go to DELIVER.
  - Else, if the counter has reached timeout_p-1, confirmed_r=0 and confirm_i[owner]=0: aborted=1, count=0, go to DELIVER.
  - Priority: li_v_i > confirm > timeout.
  - A confirmed session never times out.
  - li_v_i outside SEARCH is ignored; li_yumi_o stays 0.
- DELIVER:
  - resp_v_o[owner]=1; resp_count_o and resp_aborted_o are registered values, stable until consumed.
  - resp_yumi_i[owner] → IDLE next cycle. Non-owner yumi is ignored.
  - No new request is accepted in this cycle.
- Arbitration fairness: with every requester continuously requesting, each one is granted once every num_req_p sessions.
- Outputs:
  - req_ready_o, li_yumi_o and confirm_discovery_o are combinational from state/inputs.
  - All other outputs are registered or decoded from state.

Test Plan:
- Single flow, num_req_p=4:
  - Stimulus: req_v_i=0001 with pc 0x8000_0040; confirm_i[0] at SEARCH cycle 5; li_v_i with count 12 at cycle 9.
  - Response: start pulse at T+1 with pc 0x8000_0040; confirm_discovery_o held from cycle 5; li_yumi_o coincides with li_v_i; resp_v_o=0001, count 12, aborted 0; IDLE after yumi.
- Contention:
  - Stimulus: req_v_i=1111 held continuously.
  - Response: grant order 0,1,2,3,0; owner_o matches each grant.
- Timeout, timeout_p=16:
  - Stimulus: no confirm and no li_v_i.
  - Response: DELIVER entered after 16 SEARCH cycles with resp_aborted_o=1 and count 0; no confirm_discovery_o is ever asserted.
- Boundary:
  - Stimulus: confirm_i[owner] on the timeout cycle, then li_v_i 40 cycles later.
  - Response: no abort; result delivered.
  - Stimulus: li_v_i on the timeout cycle.
  - Response: result wins, aborted=0.
- Isolation:
  - Stimulus: owner=2; confirm_i=0001 and resp_yumi_i=0001 pulsed.
  - Response: confirm_discovery_o stays 0, DELIVER holds; resp_yumi_i=0100 then releases it.
- Reset mid-SEARCH:
  - Stimulus: reset_n_i=0 for 1 cycle.
  - Response: all outputs 0 next cycle, rr pointer 0; a new req_v_i=0010 is granted to requester 1.
